operand_reg_ctrl: RTL



---
 rtl/operand_pkg.sv | 19 +
 rtl/operand_skid_fifo.sv | 55 +++++
 rtl/operand_reg_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/operand_pkg.sv
// Shared definitions for the operand register sequencing controller.
// Defaults, command encodings and the controller state type.
package operand_pkg;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_ADDR_WIDTH  = 4;
  localparam int DEF_MATRIX_SIZE = 16;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_DRAIN = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/operand_skid_fifo.sv
// Two-entry valid/ready FIFO that absorbs DRAIN read data (word plus last flag)
// so the registered operand read can run ahead of a stalling consumer.
module operand_skid_fifo
  import operand_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_push;
  logic             w_pop;

  assign in_ready_o  = (r_count != 2'd2);
  assign out_valid_o = (r_count != 2'd0);
  assign out_data_o  = r_mem[r_rd_ptr];
  assign w_push      = in_valid_i & in_ready_o;
  assign w_pop       = out_valid_o & out_ready_i;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: payload storage is deliberately not reset; out_valid_o (driven by the
  // reset count) qualifies it, and leaving it unreset keeps it plain flops.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data_i;
  end

endmodule

// File: rtl/operand_reg_ctrl.sv
// Sequencing controller in front of the 16 x 32-bit operand register: LOAD streams
// input words into consecutive addresses, DRAIN streams them back out.
module operand_reg_ctrl
  import operand_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int MATRIX_SIZE = DEF_MATRIX_SIZE
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_op_i,
  input  logic [ADDR_WIDTH-1:0] cmd_base_i,
  input  logic [ADDR_WIDTH:0]   cmd_len_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_last_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] mat_addr_o,
  output logic [DATA_WIDTH-1:0] mat_wdata_o,
  output logic                  mat_we_o,
  input  logic [DATA_WIDTH-1:0] mat_rdata_i
);

  localparam logic [ADDR_WIDTH:0]   LEN_MAX  = (ADDR_WIDTH+1)'(MATRIX_SIZE);
  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   LEN_ZERO = '0;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_e                r_state;
  state_e                w_next_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_remaining;
  logic                  r_rd_pending;
  logic                  r_rd_last;

  logic [ADDR_WIDTH:0]   w_len;
  logic                  w_cmd_fire;
  logic                  w_load_fire;
  logic                  w_rd_issue;
  logic                  w_fifo_in_ready;
  logic                  w_fifo_out_valid;
  logic [DATA_WIDTH:0]   w_fifo_out_data;
  logic                  w_pop;
  logic [2:0]            w_occupancy;
  logic [2:0]            w_inflight;

  assign w_len       = (cmd_len_i > LEN_MAX) ? LEN_MAX : cmd_len_i;
  assign w_cmd_fire  = (r_state == ST_IDLE) & cmd_valid_i;
  assign w_load_fire = (r_state == ST_LOAD) & in_valid_i;
  assign w_pop       = w_fifo_out_valid & out_ready_i;

  // FIFO occupancy recovered from its handshake flags: 0, 1 or 2 entries.
  assign w_occupancy = {1'b0, ~w_fifo_in_ready, w_fifo_in_ready & w_fifo_out_valid};
  // A word leaving this cycle frees its slot in time for a read issued now,
  // which is what allows one word per cycle with the consumer always ready.
  assign w_inflight  = w_occupancy + {2'b00, r_rd_pending} - {2'b00, w_pop};
  assign w_rd_issue  = (r_state == ST_DRAIN) && (r_remaining != LEN_ZERO) &&
                       (w_inflight < 3'd2);

  assign mat_addr_o  = r_addr;
  assign out_valid_o = w_fifo_out_valid;
  assign out_data_o  = w_fifo_out_data[DATA_WIDTH-1:0];
  assign out_last_o  = w_fifo_out_valid & w_fifo_out_data[DATA_WIDTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    cmd_ready_o  = 1'b0;
    in_ready_o   = 1'b0;
    mat_we_o     = 1'b0;
    mat_wdata_o  = '0;
    done_o       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          if (w_len == LEN_ZERO)      w_next_state = ST_DONE;
          else if (cmd_op_i == OP_DRAIN) w_next_state = ST_DRAIN;
          else                        w_next_state = ST_LOAD;
        end
      end
      ST_LOAD: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          mat_we_o    = 1'b1;
          mat_wdata_o = in_data_i;
          if (r_remaining == LEN_ONE) w_next_state = ST_DONE;
        end
      end
      ST_DRAIN: begin
        if ((r_remaining == LEN_ZERO) && !r_rd_pending && !w_fifo_out_valid)
          w_next_state = ST_DONE;
      end
      ST_DONE: begin
        done_o       = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr       <= '0;
      r_remaining  <= '0;
      r_rd_pending <= 1'b0;
      r_rd_last    <= 1'b0;
    end else begin
      r_rd_pending <= w_rd_issue;
      if (w_rd_issue) r_rd_last <= (r_remaining == LEN_ONE);
      if (w_cmd_fire) begin
        r_addr      <= cmd_base_i;
        r_remaining <= w_len;
      end else if (w_load_fire || w_rd_issue) begin
        r_addr      <= r_addr + ADDR_ONE;
        r_remaining <= r_remaining - LEN_ONE;
      end
    end
  end

  // Read data arrives the cycle after its address was presented.
  operand_skid_fifo #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_skid_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (r_rd_pending),
    .in_ready_o  (w_fifo_in_ready),
    .in_data_i   ({r_rd_last, mat_rdata_i}),
    .out_valid_o (w_fifo_out_valid),
    .out_ready_i (out_ready_i),
    .out_data_o  (w_fifo_out_data)
  );

endmodule
